button_event_arbiter: RTL

- Front-end controller for the UnidadDeControl. Takes N raw push-button inputs and conditions each one: synchronisation, debounce, and short/long press classification.
- Classified press events are queued per button. A round-robin arbiter presents them one at a time to the main control FSM over a valid/ready handshake.
- Replaces ad-hoc per-button toggle logic. The control FSM sees discrete, ordered, never-duplicated events.

---
 rtl/button_event_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/button_event_arbiter.sv
// button_event_arbiter
//   Conditions N raw push buttons (polarity normalise, 2-FF sync, debounce,
//   short/long classification), queues one short and one long pending event
//   per button, and offers them one at a time over valid/ready using a
//   round-robin pointer that resumes after the last granted button.
// Ports
//   clk, rst       clock, asynchronous active-low reset
//   btn_in[N]      raw asynchronous button levels
//   evt_valid/evt_ready/evt_id/evt_long   event handshake
//   dropped[N]     sticky per-button overflow, cleared by clr_drop (set wins)

// Per-button conditioning and pending-event storage.
module button_event_lane #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic clr_long,
  input  logic clr_short,
  input  logic clr_drop,
  output logic pend_long,
  output logic pend_short,
  output logic dropped
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_TRIG = HW'(LONG_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          db_q;
  logic [CW-1:0] cnt_q;
  logic [HW-1:0] hold_q;
  logic          synced, flip, fall, long_hit, short_hit, drop_ev;

  assign synced    = sync_q[1];
  assign flip      = (synced != db_q) && (cnt_q == DB_LAST);
  assign fall      = flip && db_q;
  // A release landing on the same edge the hold would reach LONG is still
  // short: the button is no longer held when the threshold is crossed.
  assign long_hit  = db_q && !fall && (hold_q == HOLD_TRIG);
  assign short_hit = fall && (hold_q != HOLD_MAX);
  // A set into a bit being consumed on this edge is not an overflow.
  assign drop_ev   = (long_hit && pend_long && !clr_long) ||
                     (short_hit && pend_short && !clr_short);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      db_q       <= 1'b0;
      cnt_q      <= '0;
      hold_q     <= '0;
      pend_long  <= 1'b0;
      pend_short <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn ^ ACTIVE_LOW};
      if (synced == db_q) cnt_q <= '0;
      else if (flip) begin
        db_q  <= synced;
        cnt_q <= '0;
      end else cnt_q <= cnt_q + 1'b1;
      if (!db_q) hold_q <= '0;
      else if (hold_q != HOLD_MAX) hold_q <= hold_q + 1'b1;
      pend_long  <= (pend_long && !clr_long) || long_hit;
      pend_short <= (pend_short && !clr_short) || short_hit;
      dropped    <= (dropped && !clr_drop) || drop_ev;
    end
  end
endmodule

module button_event_arbiter #(
  parameter  int N               = 4,
  parameter  int DEBOUNCE_CYCLES = 65536,
  parameter  int LONG_CYCLES     = 50000000,
  parameter  int ACTIVE_LOW      = 1,
  localparam int IDW             = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   btn_in,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic           evt_long,
  output logic [N-1:0]   dropped,
  input  logic           clr_drop
);
  localparam int IW1 = IDW + 1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           lng;
  } evt_t;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t         state_q, state_n;
  evt_t           evt_q, evt_n;
  logic [IDW-1:0] ptr_q, ptr_n, sel;
  logic [IW1-1:0] cand;
  logic           found;
  logic [N-1:0]   pend_long, pend_short, pend_any, clr_long, clr_short;

  button_event_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW != 0)
  ) u_lane [N-1:0] (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn_in),
    .clr_long  (clr_long),
    .clr_short (clr_short),
    .clr_drop  (clr_drop),
    .pend_long (pend_long),
    .pend_short(pend_short),
    .dropped   (dropped)
  );

  assign pend_any = pend_long | pend_short;

  // Round-robin search: first pending button at ptr+1, ptr+2, ... (mod N).
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, ptr_q} + IW1'(k);
      if (cand >= IW1'(N)) cand = cand - IW1'(N);
      if (!found && pend_any[cand[IDW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_n   = state_q;
    evt_n     = evt_q;
    ptr_n     = ptr_q;
    clr_long  = '0;
    clr_short = '0;
    case (state_q)
      IDLE: if (found) begin
        evt_n.id       = sel;
        evt_n.lng      = pend_long[sel];
        clr_long[sel]  = pend_long[sel];
        clr_short[sel] = !pend_long[sel];
        state_n        = OFFER;
      end
      OFFER: if (evt_ready) begin
        ptr_n   = evt_q.id;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      evt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_n;
      evt_q   <= evt_n;
      ptr_q   <= ptr_n;
    end
  end

  assign evt_valid = (state_q == OFFER);
  assign evt_id    = evt_q.id;
  assign evt_long  = evt_q.lng;
endmodule
